// File: rtl/tst_din_mgen.sv
// ---------------------------------------------------------------------------
// tst_din_mgen -- test data generator feeding a write FIFO.
//
// Produces runs of 64*NLANE-bit words, each holding 2*NLANE complex-sample
// components (lane = k/2, even k real, odd k imaginary). Every component is
// a SWID-bit sample formatted as {sign, TAG, magnitude bits} in a 32-bit
// field. Sample sources: one PRBS31 (x^31+x^28+1) per component, a global
// ramp, or a constant.
//
// A run is len*nblk words. One word is issued per RUN cycle while fifo_af is
// low. Each issued word reaches fifo_we/fifo_wd two cycles later.
//
// Ports
//   clk        in   single clock
//   srst       in   synchronous active-high reset
//   start      in   run request pulse (accepted only when idle)
//   abort      in   stop issuing words (RUN only)
//   mode       in   0 PRBS, 1 ramp, 2 constant, 3 PRBS
//   cfg_len    in   words per block (0 means 1)
//   cfg_nblk   in   blocks per run (0 means 1)
//   cfg_const  in   constant sample value
//   fifo_af    in   FIFO almost full, holds off issue
//   fifo_we    out  FIFO write strobe
//   fifo_wd    out  FIFO write data
//   done       out  high when idle
//   busy       out  high in RUN and DRAIN
//   err        out  sticky: start seen while busy
// ---------------------------------------------------------------------------
module tst_din_mgen #(
    parameter int               NLANE      = 1,
    parameter int               SWID       = 28,
    parameter logic [31-SWID:0] TAG        = 4'd8,
    parameter logic [63:0]      SEED       = 64'h1234589abcdef,
    parameter int               LENW       = 20,
    parameter bit               RESEED_BLK = 1'b0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [LENW-1:0]       cfg_len,
    input  logic [LENW-1:0]       cfg_nblk,
    input  logic [SWID-1:0]       cfg_const,
    input  logic                  fifo_af,
    output logic                  fifo_we,
    output logic [64*NLANE-1:0]   fifo_wd,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int NC = 2 * NLANE;  // components per word

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t state_q, state_d;

    logic [1:0]          mode_q;
    logic [LENW-1:0]     len_q, nblk_q, wcnt_q, bcnt_q;
    logic [SWID-1:0]     const_q, ramp_q;
    logic [30:0]         prbs_q    [NC];
    logic [30:0]         prbs_base [NC];
    logic [30:0]         prbs_nxt  [NC];
    logic [SWID-1:0]     samp      [NC];
    logic [64*NLANE-1:0] word_c, d1_q;
    logic                v1_q;
    logic                issue, start_ok, last_word;

    // Per-component seed; all-zero would lock the LFSR, so it becomes 1.
    function automatic logic [30:0] seed_of(input int k);
        logic [30:0] h;
        h = 31'(SEED[31:0] ^ SEED[63:32] ^ (32'(k + 1) * 32'h9E3779B9));
        return (h == 31'd0) ? 31'd1 : h;
    endfunction

    // Advance a Fibonacci PRBS31 by SWID bits; the newest bit enters at
    // bit 0, so the low SWID bits of the result are the fresh output bits.
    function automatic logic [30:0] prbs_adv(input logic [30:0] s);
        logic [30:0] r;
        r = s;
        for (int i = 0; i < SWID; i++)
            r = {r[29:0], r[30] ^ r[27]};
        return r;
    endfunction

    assign start_ok  = (state_q == IDLE) && start;
    assign last_word = (wcnt_q == len_q - LENW'(1)) && (bcnt_q == nblk_q - LENW'(1));

    // ---------------- FSM: state register ----------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (srst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: each combinational output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort || (issue && last_word)) state_d = DRAIN;
            // Leaving when stage 1 is empty: the word now in stage 2 is
            // written this cycle, so done rises right after the final write.
            DRAIN:   if (!v1_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            RUN: begin
                busy  = 1'b1;
                issue = !fifo_af;
            end
            DRAIN:   busy = 1'b1;
            default: done = 1'b1;
        endcase
    end

    // ---------------- sample generation ----------------
    always_comb begin
        word_c = '0;
        for (int k = 0; k < NC; k++) begin
            prbs_base[k] = (RESEED_BLK && wcnt_q == '0) ? seed_of(k) : prbs_q[k];
            prbs_nxt[k]  = prbs_adv(prbs_base[k]);
            case (mode_q)
                2'd1:    samp[k] = ramp_q + SWID'(k);
                2'd2:    samp[k] = const_q;
                default: samp[k] = prbs_nxt[k][SWID-1:0];
            endcase
            word_c[32*k +: 32] = {samp[k][SWID-1], TAG, samp[k][SWID-2:0]};
        end
    end

    // ---------------- run configuration and counters ----------------
    // NOTE: the PRBS state array is deliberately reset (to the seeds), since
    // a run's first word depends on it; it is a small register file, not RAM.
    always_ff @(posedge clk) begin
        if (srst) begin
            mode_q  <= '0;
            len_q   <= LENW'(1);
            nblk_q  <= LENW'(1);
            const_q <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            ramp_q  <= '0;
            for (int k = 0; k < NC; k++) prbs_q[k] <= seed_of(k);
        end else if (start_ok) begin
            mode_q  <= mode;
            len_q   <= (cfg_len  == '0) ? LENW'(1) : cfg_len;
            nblk_q  <= (cfg_nblk == '0) ? LENW'(1) : cfg_nblk;
            const_q <= cfg_const;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            ramp_q  <= '0;
            for (int k = 0; k < NC; k++) prbs_q[k] <= seed_of(k);
        end else if (issue) begin
            for (int k = 0; k < NC; k++) prbs_q[k] <= prbs_nxt[k];
            // Ramp index counts words across blocks; it never restarts.
            ramp_q <= ramp_q + SWID'(NC);
            if (wcnt_q == len_q - LENW'(1)) begin
                wcnt_q <= '0;
                bcnt_q <= bcnt_q + LENW'(1);
            end else begin
                wcnt_q <= wcnt_q + LENW'(1);
            end
        end
    end

    // ---------------- sticky error ----------------
    always_ff @(posedge clk) begin
        if (srst)                            err <= 1'b0;
        else if (start_ok)                   err <= 1'b0;
        else if (start && state_q != IDLE)   err <= 1'b1;
    end

    // ---------------- two-stage write pipeline ----------------
    // Reset clears both stages, which drops words in flight.
    always_ff @(posedge clk) begin
        if (srst) begin
            v1_q    <= 1'b0;
            d1_q    <= '0;
            fifo_we <= 1'b0;
            fifo_wd <= '0;
        end else begin
            v1_q    <= issue;
            fifo_we <= v1_q;
            if (issue) d1_q    <= word_c;
            if (v1_q)  fifo_wd <= d1_q;
        end
    end

endmodule

// File: tb/tb_tst_din_mgen.sv
// ---------------------------------------------------------------------------
// tb_tst_din_mgen -- self-checking bench for tst_din_mgen.
//
// Two instances share all inputs except start: u_dut0 uses the defaults
// (NLANE=1, RESEED_BLK=0), u_dut1 uses NLANE=4, RESEED_BLK=1. Only one runs
// at a time. Starting a run pushes the model's full expected word sequence
// onto a queue; a negedge monitor pops and compares every fifo_we word.
// ---------------------------------------------------------------------------
module tb_tst_din_mgen;

    localparam logic [63:0] SEED_TB = 64'h1234589abcdef;

    logic         clk = 1'b0;
    logic         srst, start0, start1, abort, fifo_af;
    logic [1:0]   mode;
    logic [19:0]  cfg_len, cfg_nblk;
    logic [27:0]  cfg_const;
    logic         we0, we1, done0, done1, busy0, busy1, err0, err1;
    logic [63:0]  wd0;
    logic [255:0] wd1;

    always #5 clk = ~clk;

    tst_din_mgen #(.NLANE(1)) u_dut0 (
        .clk(clk), .srst(srst), .start(start0), .abort(abort), .mode(mode),
        .cfg_len(cfg_len), .cfg_nblk(cfg_nblk), .cfg_const(cfg_const),
        .fifo_af(fifo_af), .fifo_we(we0), .fifo_wd(wd0),
        .done(done0), .busy(busy0), .err(err0)
    );

    tst_din_mgen #(.NLANE(4), .RESEED_BLK(1'b1)) u_dut1 (
        .clk(clk), .srst(srst), .start(start1), .abort(abort), .mode(mode),
        .cfg_len(cfg_len), .cfg_nblk(cfg_nblk), .cfg_const(cfg_const),
        .fifo_af(fifo_af), .fifo_we(we1), .fifo_wd(wd1),
        .done(done1), .busy(busy1), .err(err1)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           wr_cnt0  = 0;
    int           wr_cnt1  = 0;
    logic [255:0] exp_q [$];
    logic [255:0] first_wd1 = '0;
    logic         af_chk = 1'b0;
    logic         af_d1  = 1'b0;
    logic         af_d2  = 1'b0;
    logic [30:0]  m_st [8];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input logic [255:0] w);
        if (exp_q.size() == 0) check("sb_underflow", 256'(1), 256'(0));
        else                   check("word", w, exp_q.pop_front());
    endtask

    // Write monitor; also checks that every write was issued in a cycle
    // where fifo_af was low (two cycles before the write).
    always @(negedge clk) begin
        if (we0) begin
            wr_cnt0++;
            sb_pop(256'(wd0));
            if (af_chk) check("af_window", 256'(af_d2), 256'(0));
        end
        if (we1) begin
            if (wr_cnt1 == 0) first_wd1 = wd1;
            wr_cnt1++;
            sb_pop(wd1);
        end
        af_d2 = af_d1;
        af_d1 = fifo_af;
    end

    // ---------------- reference model ----------------
    function automatic logic [30:0] seed_of(input int k);
        logic [31:0] h;
        h = SEED_TB[31:0] ^ SEED_TB[63:32] ^ (32'(k + 1) * 32'h9E3779B9);
        return (h[30:0] == 31'd0) ? 31'd1 : h[30:0];
    endfunction

    // Generates 28 fresh PRBS bits; the first generated bit is the MSB.
    function automatic logic [27:0] prbs_sample(input int k);
        logic [27:0] s;
        logic        b;
        s = '0;
        for (int i = 0; i < 28; i++) begin
            b = m_st[k][30] ^ m_st[k][27];
            m_st[k] = {m_st[k][29:0], b};
            s = {s[26:0], b};
        end
        return s;
    endfunction

    task automatic model_push(input int nl, input logic [1:0] md, input int len,
                              input int nblk, input logic [27:0] cst, input bit reseed);
        int           l, b;
        logic [255:0] w;
        logic [27:0]  s;
        l = (len == 0) ? 1 : len;
        b = (nblk == 0) ? 1 : nblk;
        for (int k = 0; k < 2 * nl; k++) m_st[k] = seed_of(k);
        for (int n = 0; n < l * b; n++) begin
            if (reseed && (n % l) == 0)
                for (int k = 0; k < 2 * nl; k++) m_st[k] = seed_of(k);
            w = '0;
            for (int k = 0; k < 2 * nl; k++) begin
                case (md)
                    2'd1:    s = 28'(n * 2 * nl + k);
                    2'd2:    s = cst;
                    default: s = prbs_sample(k);
                endcase
                w[32*k +: 32] = {s[27], 4'd8, s[26:0]};
            end
            exp_q.push_back(w);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Returns one cycle after the start edge (first issue cycle).
    task automatic start_run(input int sel, input logic [1:0] md, input int len,
                             input int nblk, input logic [27:0] cst, input bit ab);
        model_push((sel == 0) ? 1 : 4, md, len, nblk, cst, sel == 1);
        @(posedge clk); #1;
        mode = md; cfg_len = 20'(len); cfg_nblk = 20'(nblk); cfg_const = cst;
        abort = ab;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        // Scramble the config inputs: the running job must not see this.
        mode = ~md; cfg_len = 20'd3; cfg_nblk = 20'd5; cfg_const = 28'hFFFFFFF;
    endtask

    task automatic wait_done(input int sel, input int budget, input bit rand_af);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rand_af) fifo_af = ($urandom_range(0, 2) == 0);
            if ((sel == 0) ? done0 : done1) begin
                ok = 1'b1;
                break;
            end
        end
        fifo_af = 1'b0;
        check("run_timeout", 256'(ok), 256'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        srst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; fifo_af = 1'b0;
        mode = '0; cfg_len = '0; cfg_nblk = '0; cfg_const = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",   256'(we0),   256'(0));
        check("rst_wd",   256'(wd0),   256'(0));
        check("rst_done", 256'(done0), 256'(1));
        check("rst_busy", 256'(busy0), 256'(0));
        check("rst_err",  256'(err0),  256'(0));
        srst = 1'b0;
        repeat (2) @(posedge clk);

        // PRBS, len 16: latency, burst, done timing.
        wr_cnt0 = 0;
        start_run(0, 2'd0, 16, 1, 28'd0, 1'b0);
        check("done_fall", 256'(done0), 256'(0));
        check("busy_run",  256'(busy0), 256'(1));
        @(posedge clk); #1;
        check("we_lat2", 256'(we0), 256'(0));
        @(posedge clk); #1;
        check("we_lat3", 256'(we0), 256'(1));
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("we_burst", 256'(we0), 256'(1));
        end
        check("done_last_wr", 256'(done0), 256'(0));
        @(posedge clk); #1;
        check("we_after", 256'(we0),   256'(0));
        check("done_rise", 256'(done0), 256'(1));
        check("t1_cnt", 256'(wr_cnt0), 256'(16));
        check("t1_sb",  256'(exp_q.size()), 256'(0));

        // NLANE=4 ramp over 3 blocks of 4.
        wr_cnt1 = 0;
        start_run(1, 2'd1, 4, 3, 28'd0, 1'b0);
        wait_done(1, 200, 1'b0);
        check("ramp_cnt", 256'(wr_cnt1), 256'(12));
        check("ramp_w0",  256'(first_wd1[31:0]), 256'(32'h4000_0000));
        check("ramp_sb",  256'(exp_q.size()), 256'(0));

        // Reseed per block (dut1) vs free-running PRBS (dut0).
        wr_cnt1 = 0;
        start_run(1, 2'd0, 8, 2, 28'd0, 1'b0);
        wait_done(1, 200, 1'b0);
        check("reseed_cnt", 256'(wr_cnt1), 256'(16));
        wr_cnt0 = 0;
        start_run(0, 2'd0, 8, 2, 28'd0, 1'b0);
        wait_done(0, 200, 1'b0);
        check("noreseed_cnt", 256'(wr_cnt0), 256'(16));
        check("reseed_sb", 256'(exp_q.size()), 256'(0));

        // 1000 words with random backpressure.
        wr_cnt0 = 0;
        af_chk  = 1'b1;
        start_run(0, 2'd0, 1000, 1, 28'd0, 1'b0);
        wait_done(0, 6000, 1'b1);
        af_chk = 1'b0;
        check("af_cnt", 256'(wr_cnt0), 256'(1000));
        check("af_sb",  256'(exp_q.size()), 256'(0));

        // Zero length/blocks means one word; constant with sign bit set.
        wr_cnt0 = 0;
        start_run(0, 2'd2, 0, 0, 28'h8ABCDEF, 1'b0);
        wait_done(0, 50, 1'b0);
        check("len0_cnt", 256'(wr_cnt0), 256'(1));
        // Reserved mode behaves as PRBS.
        wr_cnt0 = 0;
        start_run(0, 2'd3, 5, 1, 28'd0, 1'b0);
        wait_done(0, 50, 1'b0);
        check("mode3_cnt", 256'(wr_cnt0), 256'(5));
        check("mode3_sb",  256'(exp_q.size()), 256'(0));

        // Abort at the 5th word of 100.
        wr_cnt0 = 0;
        start_run(0, 2'd0, 100, 1, 28'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done(0, 50, 1'b0);
        check("abort_cnt",  256'(wr_cnt0 >= 5 && wr_cnt0 <= 7), 256'(1));
        check("abort_done", 256'(done0), 256'(1));
        check("abort_busy", 256'(busy0), 256'(0));
        exp_q.delete();

        // Start while busy: ignored, sets err.
        wr_cnt0 = 0;
        start_run(0, 2'd2, 20, 1, 28'h0000123, 1'b0);
        repeat (3) @(posedge clk);
        #1 start0 = 1'b1; mode = 2'd0; cfg_len = 20'd50;
        @(posedge clk); #1 start0 = 1'b0;
        check("err_set", 256'(err0), 256'(1));
        wait_done(0, 100, 1'b0);
        check("busy_start_cnt", 256'(wr_cnt0), 256'(20));
        check("err_sticky", 256'(err0), 256'(1));
        check("busy_start_sb", 256'(exp_q.size()), 256'(0));

        // Successful start (with abort in the same idle cycle) clears err.
        wr_cnt0 = 0;
        start_run(0, 2'd2, 2, 1, 28'h0000005, 1'b1);
        check("err_clear", 256'(err0), 256'(0));
        wait_done(0, 50, 1'b0);
        check("start_abort_cnt", 256'(wr_cnt0), 256'(2));

        // Reset mid-run at word 10, then rerun from scratch.
        wr_cnt0 = 0;
        start_run(0, 2'd0, 30, 1, 28'd0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wr_cnt0 >= 10) begin
                found = 1'b1;
                break;
            end
        end
        check("srst_reach10", 256'(found), 256'(1));
        srst = 1'b1;
        @(posedge clk); #1;
        check("srst_we",   256'(we0),   256'(0));
        check("srst_done", 256'(done0), 256'(1));
        check("srst_busy", 256'(busy0), 256'(0));
        srst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 wr_cnt0 = 0;
        start_run(0, 2'd0, 30, 1, 28'd0, 1'b0);
        wait_done(0, 100, 1'b0);
        check("rerun_cnt", 256'(wr_cnt0), 256'(30));
        check("rerun_sb",  256'(exp_q.size()), 256'(0));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
